moore_seq_detect: RTL and testbench

- Parametrised Moore-style serial pattern detector, generalising the fixed 4-state Moore FSM.
- Recognises a configurable LEN-bit pattern on a single-bit serial input qualified by a sample enable.
- Supports runtime-selectable overlapping or non-overlapping detection and keeps a saturating hit counter.
- Sits on serial control/data lines as a framing/sync-word detector; z feeds downstream control logic.

---
 rtl/moore_seq_detect.sv | 118 +++++++++++
 tb/tb_moore_seq_detect.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detect.sv
// Moore serial pattern detector: KMP transition table built at elaboration,
// overlapping / non-overlapping detection, saturating hit counter.
module moore_seq_detect #(
  parameter int              LEN     = 4,
  parameter logic [LEN-1:0]  PATTERN = 4'b1011,
  parameter int              CNT_W   = 8,
  localparam int             SW      = $clog2(LEN+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             a,
  input  logic             overlap,
  input  logic             clr,
  output logic             z,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cnt_sat
);

  typedef logic [SW-1:0] state_t;

  // Rows 0..LEN-1 are matched-prefix states; row LEN is DETECT with overlap,
  // row LEN+1 is DETECT without overlap.
  localparam int ROWS = LEN + 2;
  localparam int RW   = $clog2(ROWS);

  // Longest suffix of (first k pattern bits, then b) that is a pattern prefix.
  function automatic int kmp_next(input int k, input int b);
    int  res;
    int  idx;
    bit  ok;
    bit  c;
    res = 0;
    for (int l = 1; l <= k + 1; l++) begin
      if (l <= LEN) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          idx = k + 1 - l + j;
          c   = (idx == k) ? (b != 0) : PATTERN[LEN-1-idx];
          if (c != PATTERN[LEN-1-j]) ok = 1'b0;
        end
        if (ok) res = l;
      end
    end
    return res;
  endfunction

  function automatic int kmp_fail();
    int res;
    bit ok;
    res = 0;
    for (int l = 1; l < LEN; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++)
        if (PATTERN[l-1-j] != PATTERN[LEN-1-j]) ok = 1'b0;
      if (ok) res = l;
    end
    return res;
  endfunction

  localparam int FAIL = kmp_fail();

  state_t nxt_tab [ROWS][2];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int SRC = (r < LEN) ? r : ((r == LEN) ? FAIL : 0);
      assign nxt_tab[r][b] = SW'(kmp_next(SRC, b));
    end
  end

  state_t           state_q, state_d;
  logic             z_q;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             sat_q, sat_d;
  logic [RW-1:0]    row;
  logic             hit;

  always_comb begin
    row = '0;
    if (state_q == SW'(LEN))     row = overlap ? RW'(LEN) : RW'(LEN + 1);
    else if (state_q < SW'(LEN)) row = RW'(state_q);

    state_d = en ? nxt_tab[row][a] : state_q;
    hit     = en && (state_d == SW'(LEN));

    hit_cnt_d = hit_cnt_q;
    sat_d     = sat_q;
    if (clr) begin
      hit_cnt_d = '0;
      sat_d     = 1'b0;
    end else if (hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
      sat_d     = sat_q | (hit_cnt_d == '1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= '0;
      z_q       <= 1'b0;
      hit_cnt_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_q       <= (state_d == SW'(LEN));
      hit_cnt_q <= hit_cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign z       = z_q;
  assign state   = state_q;
  assign hit_cnt = hit_cnt_q;
  assign cnt_sat = sat_q;

endmodule

// File: tb/tb_moore_seq_detect.sv
// Bench for moore_seq_detect: history-based reference model plus directed
// literal checks, then randomized traffic with async reset pulses.
module tb_moore_seq_detect;
  localparam int LEN = 4;
  localparam int SW  = 3;

  logic clk = 0, reset = 0, en = 0, a = 0, overlap = 1, clr = 0;
  logic          z0, z1, sat0, sat1;
  logic [SW-1:0] st0, st1;
  logic [7:0]    cnt0;
  logic [1:0]    cnt1;

  moore_seq_detect u_dut (
    .clk(clk), .reset(reset), .en(en), .a(a), .overlap(overlap), .clr(clr),
    .z(z0), .state(st0), .hit_cnt(cnt0), .cnt_sat(sat0));

  moore_seq_detect #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .a(a), .overlap(overlap), .clr(clr),
    .z(z1), .state(st1), .hit_cnt(cnt1), .cnt_sat(sat1));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit run = 0;

  bit [LEN-1:0] pat = 4'b1011;
  bit hist[$];
  int exp_state = 0;
  int m_cnt0 = 0, m_cnt1 = 0;
  bit m_sat0 = 0, m_sat1 = 0;

  function automatic void chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
    end
  endfunction

  // Longest tail of the consumed bits (since the last restart) matching a pattern head.
  function automatic int longest();
    bit ok;
    for (int l = LEN; l >= 1; l--) begin
      if (l <= hist.size()) begin
        ok = 1;
        for (int j = 0; j < l; j++)
          if (hist[hist.size()-l+j] != pat[LEN-1-j]) ok = 0;
        if (ok) return l;
      end
    end
    return 0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    exp_state = 0;
    m_cnt0 = 0; m_cnt1 = 0; m_sat0 = 0; m_sat1 = 0;
  endfunction

  function automatic void model_edge();
    int nxt;
    bit h;
    nxt = exp_state;
    if (en) begin
      if (exp_state == LEN && !overlap) hist.delete();
      hist.push_back(a);
      if (hist.size() > LEN) void'(hist.pop_front());
      nxt = longest();
    end
    h = en && (nxt == LEN);
    if (clr) begin
      m_cnt0 = 0; m_cnt1 = 0; m_sat0 = 0; m_sat1 = 0;
    end else if (h) begin
      m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
      m_cnt1 = (m_cnt1 < 3) ? m_cnt1 + 1 : 3;
      if (m_cnt0 == 255) m_sat0 = 1;
      if (m_cnt1 == 3)   m_sat1 = 1;
    end
    exp_state = nxt;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      chk("state", int'(st0), exp_state);
      chk("z", int'(z0), int'(exp_state == LEN));
      chk("hit_cnt", int'(cnt0), m_cnt0);
      chk("cnt_sat", int'(sat0), int'(m_sat0));
      chk("state_w2", int'(st1), exp_state);
      chk("z_w2", int'(z1), int'(exp_state == LEN));
      chk("hit_cnt_w2", int'(cnt1), m_cnt1);
      chk("cnt_sat_w2", int'(sat1), int'(m_sat1));
    end
  end

  task automatic step(input bit ia, input bit ien = 1, input bit iov = 1, input bit iclr = 0);
    a = ia; en = ien; overlap = iov; clr = iclr;
    @(posedge clk); #1;
    model_edge();
  endtask

  // Called at posedge+1; reset asserted mid-cycle, released just after the next edge.
  task automatic async_reset(input bit check_now);
    #2 reset = 0;
    #1;
    if (check_now) begin
      chk("rst state", int'(st0), 0);
      chk("rst z", int'(z0), 0);
      chk("rst hit_cnt", int'(cnt0), 0);
      chk("rst cnt_sat", int'(sat0), 0);
      chk("rst hit_cnt_w2", int'(cnt1), 0);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic feed_states(input string nm, input bit bits[], input int sts[], input bit ov);
    for (int i = 0; i < bits.size(); i++) begin
      step(bits[i], 1, ov);
      chk({nm, " state"}, int'(st0), sts[i]);
      chk({nm, " model"}, exp_state, sts[i]);
    end
  endtask

  initial begin
    bit s7[] = '{1,0,1,1,0,1,1};
    bit s4[] = '{1,0,1,1};
    int ov_st[] = '{1,2,3,4,2,3,4};
    int no_st[] = '{1,2,3,4,0,1,1};
    int p4_st[] = '{1,2,3,4};
    int exp_c[] = '{1,2,3,3};
    int exp_s[] = '{0,0,1,1};

    repeat (2) @(posedge clk);
    #1;
    chk("init state", int'(st0), 0);
    chk("init z", int'(z0), 0);
    chk("init hit_cnt", int'(cnt0), 0);
    reset = 1;
    run = 1;

    // overlapping stream
    feed_states("ovl", s7, ov_st, 1);
    chk("ovl hit_cnt", int'(cnt0), 2);

    async_reset(0);
    feed_states("novl", s7, no_st, 0);
    chk("novl hit_cnt", int'(cnt0), 1);

    // en gaps with a toggled during the gaps
    async_reset(0);
    for (int i = 0; i < 4; i++) begin
      step(s4[i], 1, 1);
      chk("gap state", int'(st0), p4_st[i]);
      step(~s4[i], 0, 1);
      chk("gap hold", int'(st0), p4_st[i]);
    end
    step(0, 0, 1);
    chk("gap z held", int'(z0), 1);
    step(0, 1, 1);
    chk("gap z drop", int'(z0), 0);
    chk("gap hit_cnt", int'(cnt0), 1);

    // saturation on the 2-bit counter, then clr against a same-edge hit
    async_reset(0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) step(s4[i], 1, 1);
      chk("sat hit_cnt", int'(cnt1), exp_c[r]);
      chk("sat model", m_cnt1, exp_c[r]);
      chk("sat flag", int'(sat1), exp_s[r]);
    end
    step(1); step(0); step(1);
    step(1, 1, 1, 1);
    chk("clr state", int'(st1), 4);
    chk("clr hit_cnt", int'(cnt1), 0);
    chk("clr cnt_sat", int'(sat1), 0);

    // async reset mid-pattern: no detection from pre-reset bits
    async_reset(0);
    for (int i = 0; i < 4; i++) step(s4[i]);
    step(1); step(0); step(1);
    chk("pre-rst state", int'(st0), 3);
    chk("pre-rst hit_cnt", int'(cnt0), 1);
    async_reset(1);
    step(1);
    chk("post-rst state", int'(st0), 1);
    chk("post-rst z", int'(z0), 0);
    chk("post-rst hit_cnt", int'(cnt0), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) async_reset(0);
      else step(1'($urandom), $urandom_range(3) != 0, 1'($urandom),
                $urandom_range(49) == 0);
    end

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
